mem_arbiter: RTL

Shares the single external memory bus between instruction fetch (IF) and the data-memory stage, where IF issues word reads and MEM issues LB/LW/SB/SW accesses. It sits between those two requesters and the memory bus. It arbitrates with fixed priority (MEM over IF), registers and holds bus signals until the memory acknowledges, and returns read data with a one-cycle ready pulse. It also drives stall outputs so the pipeline freezes while an access is outstanding.

---
 rtl/mem_arbiter_if.sv | 56 +++++
 rtl/mem_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Groups the requester handshakes (IF port, MEM port), the external memory
//   bus and the pipeline stall outputs of mem_arbiter.
//   master : arbiter view. It drives ready/read data, the bus command and the stalls.
//   slave  : environment view. It covers the requesters and the memory device.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  if_read_enable;
    logic [ADDR_WIDTH-1:0] if_read_address;
    logic [DATA_WIDTH-1:0] if_read_data;
    logic                  if_ready;

    logic                  mem_read_enable;
    logic [ADDR_WIDTH-1:0] mem_read_address;
    logic                  mem_write_enable;
    logic [ADDR_WIDTH-1:0] mem_write_address;
    logic [3:0]            mem_write_select;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic [DATA_WIDTH-1:0] mem_read_data;
    logic                  mem_ready;

    logic                  bus_request;
    logic                  bus_write_enable;
    logic [ADDR_WIDTH-1:0] bus_address;
    logic [3:0]            bus_write_select;
    logic [DATA_WIDTH-1:0] bus_write_data;
    logic [DATA_WIDTH-1:0] bus_read_data;
    logic                  bus_ack;

    logic                  stall_if;
    logic                  stall_mem;

    modport master (
        input  if_read_enable, if_read_address,
        output if_read_data, if_ready,
        input  mem_read_enable, mem_read_address, mem_write_enable,
        input  mem_write_address, mem_write_select, mem_write_data,
        output mem_read_data, mem_ready,
        output bus_request, bus_write_enable, bus_address, bus_write_select, bus_write_data,
        input  bus_read_data, bus_ack,
        output stall_if, stall_mem
    );

    modport slave (
        output if_read_enable, if_read_address,
        input  if_read_data, if_ready,
        output mem_read_enable, mem_read_address, mem_write_enable,
        output mem_write_address, mem_write_select, mem_write_data,
        input  mem_read_data, mem_ready,
        input  bus_request, bus_write_enable, bus_address, bus_write_select, bus_write_data,
        output bus_read_data, bus_ack,
        input  stall_if, stall_mem
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one external memory bus between instruction fetch (word reads) and
//   the data-memory stage (reads/writes with byte lanes). MEM has fixed
//   priority over IF. The bus command is registered when a request is granted.
//   It is held until bus_ack. Completion is reported with a one-cycle ready
//   pulse and registered read data.
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous, active-low
//   arb            mem_arbiter_if.master (IF/MEM handshakes, bus, stalls)
//   watchdog_error sticky bus-timeout flag (0 unless watchdog built in)
//
// Optional feature
//   MEM_ARB_WATCHDOG_EN: abort a bus cycle after TIMEOUT_CYCLES grant cycles
//   without bus_ack. The granted port then gets ready with read data 0.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | no bus cycle; arbitrating (MEM over IF)
// GRANT_MEM | bus cycle for the MEM port, waiting for bus_ack
// GRANT_IF  | bus cycle for the IF port, waiting for bus_ack
module mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.master arb,
    output logic          watchdog_error
);

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT_MEM = 2'd1,
        GRANT_IF  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  bus_we_q;
    logic [ADDR_WIDTH-1:0] bus_addr_q;
    logic [3:0]            bus_sel_q;
    logic [DATA_WIDTH-1:0] bus_wdata_q;
    logic [DATA_WIDTH-1:0] if_rdata_q;
    logic [DATA_WIDTH-1:0] mem_rdata_q;
    logic                  if_ready_q;
    logic                  mem_ready_q;

    logic                  mem_req;
    logic                  if_req;
    logic                  load_mem;
    logic                  load_if;
    logic                  done;
    logic                  timeout;

    // A port whose ready pulse is high this cycle is still holding its old
    // request, so it is kept out of arbitration for that cycle.
    assign mem_req = (arb.mem_read_enable | arb.mem_write_enable) & ~mem_ready_q;
    assign if_req  = arb.if_read_enable & ~if_ready_q;

`ifdef MEM_ARB_WATCHDOG_EN
    localparam int WD_WIDTH = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_WIDTH-1:0] wd_count_q;
    logic                wd_error_q;

    // The counter holds the number of ack-less grant cycles already spent.
    // The cycle that would make it TIMEOUT_CYCLES ends the bus cycle instead.
    assign timeout = (state_q != IDLE) && !arb.bus_ack &&
                     (wd_count_q == WD_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_count_q <= '0;
            wd_error_q <= 1'b0;
        end else begin
            if (load_mem || load_if) begin
                wd_count_q <= '0;
            end else if ((state_q != IDLE) && !arb.bus_ack) begin
                wd_count_q <= wd_count_q + WD_WIDTH'(1);
            end
            if (timeout) begin
                wd_error_q <= 1'b1;
            end
        end
    end

    assign watchdog_error = wd_error_q;
`else
    assign timeout        = 1'b0;
    assign watchdog_error = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        load_mem = 1'b0;
        load_if  = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    load_mem = 1'b1;
                    state_d  = GRANT_MEM;
                end else if (if_req) begin
                    load_if = 1'b1;
                    state_d = GRANT_IF;
                end
            end
            GRANT_MEM, GRANT_IF: begin
                if (arb.bus_ack || timeout) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_sel_q   <= 4'b0000;
            bus_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            if_ready_q  <= done && (state_q == GRANT_IF);
            mem_ready_q <= done && (state_q == GRANT_MEM);

            // A write wins when MEM asserts both directions. Reads drive zero
            // lanes and zero data so the bus never shows stale write values.
            if (load_mem) begin
                bus_we_q    <= arb.mem_write_enable;
                bus_addr_q  <= arb.mem_write_enable ? arb.mem_write_address : arb.mem_read_address;
                bus_sel_q   <= arb.mem_write_enable ? arb.mem_write_select : 4'b0000;
                bus_wdata_q <= arb.mem_write_enable ? arb.mem_write_data : '0;
            end else if (load_if) begin
                bus_we_q    <= 1'b0;
                bus_addr_q  <= arb.if_read_address;
                bus_sel_q   <= 4'b0000;
                bus_wdata_q <= '0;
            end

            if (done && (state_q == GRANT_IF)) begin
                if_rdata_q <= timeout ? '0 : arb.bus_read_data;
            end
            if (done && (state_q == GRANT_MEM) && !bus_we_q) begin
                mem_rdata_q <= timeout ? '0 : arb.bus_read_data;
            end
        end
    end

    assign arb.bus_request      = (state_q != IDLE);
    assign arb.bus_write_enable = bus_we_q;
    assign arb.bus_address      = bus_addr_q;
    assign arb.bus_write_select = bus_sel_q;
    assign arb.bus_write_data   = bus_wdata_q;

    assign arb.if_read_data  = if_rdata_q;
    assign arb.if_ready      = if_ready_q;
    assign arb.mem_read_data = mem_rdata_q;
    assign arb.mem_ready     = mem_ready_q;

    assign arb.stall_mem = (arb.mem_read_enable | arb.mem_write_enable) & ~mem_ready_q;
    assign arb.stall_if  = arb.if_read_enable & ~if_ready_q;

endmodule
